seq_comparator: RTL and testbench
=================================

SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits compared per cycle; WIDTH % CHUNK == 0, CHUNK >= 1.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request compare; sampled only in IDLE.
REQ-006 SHALL have port p  input  WIDTH  left operand, captured on accepted start.
REQ-007 SHALL have port q  input  WIDTH  right operand, captured on accepted start.
REQ-008 SHALL have port busy  output  1  high while state is CMP.
REQ-009 SHALL have port done  output  1  one-cycle pulse, results valid.
REQ-010 SHALL have ports EQL, LTR, GTR  output  1 each  p==q, p<q, p>q; registered.

Function
REQ-011 SHALL implement states IDLE, CMP, DONE; N = WIDTH/CHUNK.
REQ-012 SHALL, in IDLE with start=1 at edge k, capture p,q, clear EQL/LTR/GTR, enter CMP with chunk index i=0 (MSB chunk).
REQ-013 SHALL, in CMP, compare chunk i of both captured operands each cycle, unsigned, MSB-first.
REQ-014 SHALL, on first unequal chunk, set exactly one of LTR/GTR and enter DONE at edge k+1+i (early termination).
REQ-015 SHALL, when chunk N-1 is equal, set EQL and enter DONE at edge k+N.
REQ-016 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-017 SHALL ignore start in CMP and DONE; captured operands never change mid-compare.
REQ-018 SHALL hold EQL/LTR/GTR stable from DONE until the next accepted start.
REQ-019 SHALL guarantee at most one of EQL/LTR/GTR high at any time.
REQ-020 SHALL accept start in the first IDLE cycle after DONE (back-to-back rate N+2 cycles worst case).
REQ-021 SHALL, with N=1, finish in one CMP cycle.

Reset
REQ-022 SHALL, on rst high, immediately force IDLE, busy=0, done=0, EQL=LTR=GTR=0, operand registers 0.
REQ-023 SHALL abort any compare in progress on rst; no done pulse for the aborted request.
REQ-024 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL, when SEQ_CMP_SIGNED_EN is defined, add input port sgn (1 bit, captured with operands); sgn=1 selects two's-complement compare by inverting the operand MSB in chunk 0.
REQ-026 SHALL, when SEQ_CMP_SIGNED_EN is undefined, have no sgn port and compare unsigned only.

Structure
REQ-027 SHALL place the state enum (IDLE/CMP/DONE) and result encoding constants in package seq_cmp_pkg.
REQ-028 SHALL instantiate sub-module chunk_cmp: combinational CHUNK-bit comparator producing eq/lt.
REQ-029 SHALL keep the chunk index counter $clog2(N) bits wide (min 1).

Verification (WIDTH=16, CHUNK=4 unless noted)
REQ-030 SHALL cover p=0x1234, q=0x1234, start at edge k -> done high after edge k+4, EQL=1, LTR=GTR=0.
REQ-031 SHALL cover p=0x0FFF, q=0x1000 -> done after edge k+1, LTR=1; p=0x12A4, q=0x1294 -> done after edge k+3, GTR=1.
REQ-032 SHALL cover start re-pulsed with p=0, q=0xFFFF during CMP of 0x1234 vs 0x1234 -> ignored, EQL=1 reported.
REQ-033 SHALL cover rst asserted at edge k+2 of an equal compare -> outputs 0 immediately, no done, next start compares correctly.
REQ-034 SHALL cover WIDTH=4, CHUNK=1 exhaustive 256 {p,q} pairs -> EQL/LTR/GTR match reference model every done.
REQ-035 SHALL cover, with SEQ_CMP_SIGNED_EN, p=0x8000, q=0x0001: sgn=1 -> LTR=1; sgn=0 -> GTR=1.

Source files
------------

// File: rtl/seq_cmp_pkg.sv
// Shared types for the sequential chunk-wise magnitude comparator.
// The state encoding and the {EQL,LTR,GTR} result codes live here.
package seq_cmp_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Result vector ordering is {EQL, LTR, GTR}
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_EQL  = 3'b100;
    localparam logic [2:0] RES_LTR  = 3'b010;
    localparam logic [2:0] RES_GTR  = 3'b001;

endpackage

// File: rtl/seq_comparator_chunk_cmp.sv
// Combinational unsigned comparator for one CHUNK-bit slice of the operands.
module chunk_cmp #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    output logic             o_eq,
    output logic             o_lt
);

    assign o_eq = (i_a == i_b);
    assign o_lt = (i_a < i_b);

endmodule

// File: rtl/seq_comparator.sv
// Sequential MSB-first comparator: one CHUNK-bit slice per cycle, early exit on
// the first unequal slice. Optional SEQ_CMP_SIGNED_EN adds a two's-complement mode.
module seq_comparator
    import seq_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
`ifdef SEQ_CMP_SIGNED_EN
    input  logic             sgn,
`endif
    output logic             busy,
    output logic             done,
    output logic             EQL,
    output logic             LTR,
    output logic             GTR
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_q;
    logic [IW-1:0]    r_idx;
    logic             r_busy;
    logic             r_done;
    logic [2:0]       r_res;

    logic [WIDTH-1:0] w_p_sh;
    logic [WIDTH-1:0] w_q_sh;
    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;
    logic [CHUNK-1:0] w_flip_mask;
    logic             w_flip;
    logic             w_eq;
    logic             w_lt;
    logic             w_last;

`ifdef SEQ_CMP_SIGNED_EN
    logic             r_sgn;
    // Inverting both sign bits turns a signed compare into an unsigned one
    assign w_flip = r_sgn && (r_idx == '0);
`else
    assign w_flip = 1'b0;
`endif

    // Align the active slice to the top of the word, then take CHUNK bits
    assign w_p_sh      = r_p << (32'(r_idx) * CHUNK);
    assign w_q_sh      = r_q << (32'(r_idx) * CHUNK);
    assign w_flip_mask = CHUNK'(w_flip) << (CHUNK - 1);
    assign w_a         = w_p_sh[WIDTH-1 -: CHUNK] ^ w_flip_mask;
    assign w_b         = w_q_sh[WIDTH-1 -: CHUNK] ^ w_flip_mask;
    assign w_last      = (r_idx == IW'(N - 1));

    chunk_cmp #(
        .CHUNK (CHUNK)
    ) u_chunk_cmp (
        .i_a  (w_a),
        .i_b  (w_b),
        .o_eq (w_eq),
        .o_lt (w_lt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_p     <= '0;
            r_q     <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_res   <= RES_NONE;
`ifdef SEQ_CMP_SIGNED_EN
            r_sgn   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_p     <= p;
                        r_q     <= q;
`ifdef SEQ_CMP_SIGNED_EN
                        r_sgn   <= sgn;
`endif
                        r_idx   <= '0;
                        r_res   <= RES_NONE;
                        r_busy  <= 1'b1;
                        r_state <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (!w_eq || w_last) begin
                        r_res   <= !w_eq ? (w_lt ? RES_LTR : RES_GTR) : RES_EQL;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign {EQL, LTR, GTR} = r_res;

endmodule

// File: tb/tb_seq_comparator.sv
// Self-checking bench: 16/4 instance (directed + random) and 4/1 instance (exhaustive).
module tb_seq_comparator;

    logic        clk;
    logic        rst;
    logic        start0, start1;
    logic [15:0] p0, q0;
    logic [3:0]  p1, q1;
    logic        sgn0;
    logic        busy0, done0, eql0, ltr0, gtr0;
    logic        busy1, done1, eql1, ltr1, gtr1;

    int n_checks;
    int n_errors;

    seq_comparator #(.WIDTH(16), .CHUNK(4)) u_dut0 (
        .clk   (clk),
        .rst   (rst),
        .start (start0),
        .p     (p0),
        .q     (q0),
`ifdef SEQ_CMP_SIGNED_EN
        .sgn   (sgn0),
`endif
        .busy  (busy0),
        .done  (done0),
        .EQL   (eql0),
        .LTR   (ltr0),
        .GTR   (gtr0)
    );

    seq_comparator #(.WIDTH(4), .CHUNK(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .p     (p1),
        .q     (q1),
`ifdef SEQ_CMP_SIGNED_EN
        .sgn   (1'b0),
`endif
        .busy  (busy1),
        .done  (done1),
        .EQL   (eql1),
        .LTR   (ltr1),
        .GTR   (gtr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: cycles from accept to done = index of first differing slice + 1, else N
    function automatic int model_lat(input int w, input int ck, input logic [15:0] a, input logic [15:0] b);
        int n    = w / ck;
        int mask = (1 << ck) - 1;
        for (int i = 0; i < n; i++) begin
            int sh = w - ck * (i + 1);
            if ((int'(a >> sh) & mask) != (int'(b >> sh) & mask))
                return i + 1;
        end
        return n;
    endfunction

    // Reference: {EQL,LTR,GTR} from plain integer comparison
    function automatic logic [2:0] model_res(input logic [15:0] a, input logic [15:0] b, input logic s);
        int va, vb;
        if (s) begin
            va = int'($signed(a));
            vb = int'($signed(b));
        end else begin
            va = int'({16'h0, a});
            vb = int'({16'h0, b});
        end
        if (va == vb) return 3'b100;
        if (va < vb)  return 3'b010;
        return 3'b001;
    endfunction

    task automatic drive(input int which, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic st);
        if (which == 0) begin
            p0 = a; q0 = b; sgn0 = s; start0 = st;
        end else begin
            p1 = a[3:0]; q1 = b[3:0]; start1 = st;
        end
    endtask

    task automatic sample(input int which, output logic bsy, output logic dn, output logic [2:0] res);
        if (which == 0) begin
            bsy = busy0; dn = done0; res = {eql0, ltr0, gtr0};
        end else begin
            bsy = busy1; dn = done1; res = {eql1, ltr1, gtr1};
        end
    endtask

    task automatic run_cmp(input int which, input logic [15:0] a, input logic [15:0] b,
                           input logic s, input bit repulse);
        int         w       = (which == 0) ? 16 : 4;
        int         ck      = (which == 0) ? 4 : 1;
        int         lat_exp = model_lat(w, ck, a, b);
        logic [2:0] res_exp = model_res(a, b, s);
        int         lat     = 0;
        logic       bsy, dn;
        logic [2:0] res;

        @(negedge clk);
        drive(which, a, b, s, 1'b1);
        @(posedge clk); #1;
        drive(which, a, b, s, 1'b0);
        sample(which, bsy, dn, res);
        chk("busy_after_start", 32'(bsy), 32'd1);
        chk("flags_cleared", 32'(res), 32'd0);

        for (int c = 1; c <= 8; c++) begin
            if (repulse && c == 1)
                drive(which, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
            @(posedge clk); #1;
            sample(which, bsy, dn, res);
            if (dn) begin
                lat = c;
                break;
            end
        end
        drive(which, a, b, s, 1'b0);
        chk("latency", 32'(lat), 32'(lat_exp));
        chk("result", 32'(res), 32'(res_exp));
        chk("busy_in_done", 32'(bsy), 32'd0);

        @(posedge clk); #1;
        sample(which, bsy, dn, res);
        chk("done_one_cycle", 32'(dn), 32'd0);
        chk("result_hold", 32'(res), 32'(res_exp));
    endtask

    initial begin
        logic        bsy, dn;
        logic [2:0]  res;
        int          seen;
        logic [15:0] a, b;
        logic        s;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        drive(0, 16'h0, 16'h0, 1'b0, 1'b0);
        drive(1, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        sample(0, bsy, dn, res);
        chk("reset_busy", 32'(bsy), 32'd0);
        chk("reset_done", 32'(dn), 32'd0);
        chk("reset_flags", 32'(res), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_cmp(0, 16'h1234, 16'h1234, 1'b0, 1'b0);
        run_cmp(0, 16'h0FFF, 16'h1000, 1'b0, 1'b0);
        run_cmp(0, 16'h12A4, 16'h1294, 1'b0, 1'b0);
        run_cmp(0, 16'h1234, 16'h1234, 1'b0, 1'b1);
        run_cmp(0, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        run_cmp(0, 16'h0000, 16'h0001, 1'b0, 1'b0);

        // Reset in the middle of an equal compare
        @(negedge clk);
        drive(0, 16'h1234, 16'h1234, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(0, 16'h1234, 16'h1234, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        sample(0, bsy, dn, res);
        chk("abort_busy", 32'(bsy), 32'd0);
        chk("abort_done", 32'(dn), 32'd0);
        chk("abort_flags", 32'(res), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (done0) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        run_cmp(0, 16'h1234, 16'h1235, 1'b0, 1'b0);

`ifdef SEQ_CMP_SIGNED_EN
        run_cmp(0, 16'h8000, 16'h0001, 1'b1, 1'b0);
        run_cmp(0, 16'h8000, 16'h0001, 1'b0, 1'b0);
`endif

        // Random pairs, biased towards shared upper slices
        for (int i = 0; i < 200; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = 16'($urandom);
                default: b = a ^ (16'h1 << $urandom_range(0, 15));
            endcase
`ifdef SEQ_CMP_SIGNED_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            run_cmp(0, a, b, s, ($urandom_range(0, 7) == 0));
        end

        // Exhaustive single-bit-slice instance
        for (int i = 0; i < 256; i++) begin
            a = 16'(i >> 4);
            b = 16'(i & 15);
            run_cmp(1, a, b, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
